// File: rtl/adc_recepcion_multi.sv
// Multi-lane serial ADC receiver: N_CH data lines share one chip-select and SCLK.
// Define ADC_RECEPCION_CHECK_EN to flag frames whose leading (non-data) bits are non-zero.
`timescale 1ns/1ps
module adc_recepcion_multi #(
    parameter int N_CH         = 2,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                          SCLK,
    input  logic                          reset,
    input  logic [N_CH-1:0]               ADCdata,
    input  logic                          rx_en,
    output logic                          cs_n,
    output logic                          rx_done_tick,
    output logic [N_CH*FRAME_BITS-1:0]    b_reg,
    output logic [N_CH*DATA_BITS-1:0]     data_out,
    output logic                          frame_err
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t                        state_q, state_d;
    logic [BW-1:0]                 bit_cnt_q, bit_cnt_d;
    logic [QW-1:0]                 quiet_cnt_q, quiet_cnt_d;
    logic                          cs_n_q, cs_n_d;
    logic                          rx_done_tick_q, rx_done_tick_d;
    logic [N_CH*FRAME_BITS-1:0]    b_reg_q, b_reg_d;
    logic [N_CH*DATA_BITS-1:0]     data_out_q, data_out_d;
    logic [N_CH*FRAME_BITS-1:0]    shifted;
    logic [FRAME_BITS-1:0]         lane;
    logic                          frame_end;

    // Post-shift image of every lane; both the live register and the capture use it.
    always_comb begin
        shifted = '0;
        lane    = '0;
        for (int k = 0; k < N_CH; k++) begin
            lane    = b_reg_q[k*FRAME_BITS +: FRAME_BITS] << 1;
            lane[0] = ADCdata[k];
            shifted[k*FRAME_BITS +: FRAME_BITS] = lane;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        b_reg_d     = b_reg_q;
        data_out_d  = data_out_q;
        frame_end   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_en) begin
                    state_d   = CONV;
                    bit_cnt_d = '0;
                end
            end
            CONV: begin
                b_reg_d   = shifted;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                    frame_end   = 1'b1;
                    state_d     = HOLD;
                    quiet_cnt_d = '0;
                    for (int k = 0; k < N_CH; k++) begin
                        data_out_d[k*DATA_BITS +: DATA_BITS] = shifted[k*FRAME_BITS +: DATA_BITS];
                    end
                end
            end
            HOLD: begin
                quiet_cnt_d = quiet_cnt_q + 1'b1;
                if (quiet_cnt_q == QW'(QUIET_CYCLES - 1)) begin
                    if (rx_en) begin
                        state_d   = CONV;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // cs_n is registered, so it tracks the state being entered.
        cs_n_d         = (state_d != CONV);
        rx_done_tick_d = frame_end;
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            quiet_cnt_q    <= '0;
            cs_n_q         <= 1'b1;
            rx_done_tick_q <= 1'b0;
            b_reg_q        <= '0;
            data_out_q     <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            quiet_cnt_q    <= quiet_cnt_d;
            cs_n_q         <= cs_n_d;
            rx_done_tick_q <= rx_done_tick_d;
            b_reg_q        <= b_reg_d;
            data_out_q     <= data_out_d;
        end
    end

`ifdef ADC_RECEPCION_CHECK_EN
    logic err_any;
    logic frame_err_q, frame_err_d;

    // A lane is bad when anything above its DATA_BITS data field was received as 1.
    always_comb begin
        err_any = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if ((shifted[k*FRAME_BITS +: FRAME_BITS] >> DATA_BITS) != '0) begin
                err_any = 1'b1;
            end
        end
        frame_err_d = frame_end ? err_any : frame_err_q;
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign cs_n         = cs_n_q;
    assign rx_done_tick = rx_done_tick_q;
    assign b_reg        = b_reg_q;
    assign data_out     = data_out_q;
endmodule

// File: doc/adc_recepcion_multi.md
ADC_RECEPCION_MULTI -- requirements
Module: adc_recepcion_multi

Interface
REQ-001 Parameter N_CH, default 2: number of parallel serial ADC data lines sharing one chip-select and clock.
REQ-002 Parameter FRAME_BITS, default 16: SCLK cycles per conversion frame.
REQ-003 Parameter DATA_BITS, default 12: valid data bits per frame, the least-significant DATA_BITS received.
REQ-004 Parameter QUIET_CYCLES, default 2: minimum cs_n-high cycles between frames.
REQ-005 Port SCLK  in  1: single clock; all state updates on its rising edge.
REQ-006 Port reset  in  1: asynchronous, active-low reset (asserted when 0).
REQ-007 Port ADCdata  in  N_CH: serial data, bit k belongs to channel k, MSB first.
REQ-008 Port rx_en  in  1: receive enable, level-sensitive.
REQ-009 Port cs_n  out  1: ADC chip select, active low, driven from a register.
REQ-010 Port rx_done_tick  out  1: one-cycle pulse, frame complete.
REQ-011 Port b_reg  out  N_CH*FRAME_BITS: raw shift registers, channel k at [k*FRAME_BITS +: FRAME_BITS].
REQ-012 Port data_out  out  N_CH*DATA_BITS: captured data, channel k at [k*DATA_BITS +: DATA_BITS].
REQ-013 Port frame_err  out  1: leading-bit check failure flag (see Configuration).

Function
REQ-014 FSM states IDLE, CONV, HOLD; bit counter width ceil(log2(FRAME_BITS+1)); quiet counter width ceil(log2(QUIET_CYCLES+1)).
REQ-015 IDLE: cs_n=1; rx_en=1 -> CONV next cycle with cs_n=0 and bit counter cleared; rx_en=0 -> stay.
REQ-016 CONV: every rising edge shifts each channel left, ADCdata[k] into b_reg channel k LSB, counter +1.
REQ-017 CONV exit on FRAME_BITS-th shift: same edge sets cs_n=1, loads data_out channel k from low DATA_BITS of the post-shift register, enters HOLD.
REQ-018 rx_done_tick high exactly the one cycle following the FRAME_BITS-th shift edge, coincident with new data_out; never high otherwise.
REQ-019 HOLD: cs_n=1 for QUIET_CYCLES cycles, then CONV if rx_en=1 else IDLE; back-to-back frame period = FRAME_BITS+QUIET_CYCLES cycles.
REQ-020 rx_en falling mid-CONV does not abort; frame completes and reports normally; HOLD then goes to IDLE.
REQ-021 data_out and frame_err hold last values until the next frame completes; b_reg updates live during CONV and holds otherwise.
REQ-022 Legal parameters: N_CH>=1, 1<=DATA_BITS<=FRAME_BITS, QUIET_CYCLES>=1; DATA_BITS=FRAME_BITS means zero check bits and frame_err always 0.

Reset
REQ-023 reset=0 asynchronously forces state IDLE, counters 0, cs_n=1, rx_done_tick=0, b_reg=0, data_out=0, frame_err=0.
REQ-024 Reset mid-CONV discards the partial frame; no rx_done_tick; after release first frame starts from bit 0 when rx_en=1.
REQ-025 Release of reset takes effect on the next SCLK rising edge; no output changes before it.

Configuration
REQ-026 Macro ADC_RECEPCION_CHECK_EN defined: at frame end frame_err=1 if any channel's top FRAME_BITS-DATA_BITS received bits are non-zero, else 0; updated with rx_done_tick.
REQ-027 Macro ADC_RECEPCION_CHECK_EN undefined: no check logic; frame_err tied to 0; all other behaviour identical.

Verification
REQ-028 Reset held 5 cycles, rx_en=1, ch0 frame 16'h0A5C, ch1 16'h0123 -> cs_n low 16 cycles, rx_done_tick one pulse, data_out={12'h123,12'hA5C}, frame_err=0.
REQ-029 rx_en=1 continuous, 3 frames -> rx_done_tick pulses exactly 18 cycles apart (16+2), cs_n high exactly 2 cycles between frames.
REQ-030 Check enabled, ch1 frame 16'h8FFF, ch0 16'h0FFF -> frame_err=1, data_out={12'hFFF,12'hFFF}; next clean frame clears frame_err; check disabled -> frame_err stays 0.
REQ-031 reset=0 after 7 bits of a frame -> cs_n=1 immediately, no rx_done_tick, outputs 0; next full frame 16'h0555 on both channels captures 12'h555 each.
REQ-032 rx_en dropped after bit 4 -> frame completes, one rx_done_tick, FSM returns to IDLE with cs_n=1 held.
REQ-033 Parameter set N_CH=1, FRAME_BITS=14, DATA_BITS=14, QUIET_CYCLES=1 -> frame 14'h2ABC captured, period 15 cycles, frame_err 0.
